// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension pipeline.
// Mode encodings and the output FIFO depth.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational immediate extension (sign / zero / upper).
// Upper mode exists only when IMM_EXT_UPPER_EN is defined.
module imm_ext_comb #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] data,
    output logic             err
);
    import imm_ext_pkg::*;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
`ifdef IMM_EXT_UPPER_EN
    logic [OUT_W-1:0] uext;
`endif

    generate
        if (OUT_W > IN_W) begin : g_wide
            assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
            assign zext = {{(OUT_W-IN_W){1'b0}}, in_data};
`ifdef IMM_EXT_UPPER_EN
            assign uext = {in_data, {(OUT_W-IN_W){1'b0}}};
`endif
        end else begin : g_same
            assign sext = in_data;
            assign zext = in_data;
`ifdef IMM_EXT_UPPER_EN
            assign uext = in_data;
`endif
        end
    endgenerate

    // Select the extension; unknown modes fall back to zero-extend and flag err
    always_comb begin
        data = zext;
        err  = 1'b0;
        case (in_mode)
            MODE_SIGN: data = sext;
            MODE_ZERO: data = zext;
`ifdef IMM_EXT_UPPER_EN
            MODE_UPPER: data = uext;
`else
            MODE_UPPER: err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension with a 2-entry output FIFO and transfer counter.
// Optional upper mode: define IMM_EXT_UPPER_EN.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [15:0]      xfer_cnt
);
    import imm_ext_pkg::*;

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
    logic             mem_err  [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [15:0]      cnt_q;
    logic             push;
    logic             pop;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .in_data (in_data),
        .in_mode (in_mode),
        .data    (ext_data),
        .err     (ext_err)
    );

    assign in_ready  = (count < 2'(FIFO_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_err   = out_valid ? mem_err[rd_ptr] : 1'b0;
    assign xfer_cnt  = cnt_q;

    // Store the result computed on the accepting cycle
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ext_data;
            mem_err[wr_ptr]  <= ext_err;
        end
    end

    // Pointers, occupancy and saturating transfer count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            cnt_q  <= 16'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (32-bit and 8/8 instances).
// Reference model computes extensions arithmetically.
module tb_imm_ext_pipe;

`ifdef IMM_EXT_UPPER_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [15:0] xfer_cnt;

    logic        n_rst_n;
    logic        n_in_valid;
    logic        n_in_ready;
    logic [7:0]  n_in_data;
    logic [1:0]  n_in_mode;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [7:0]  n_out_data;
    logic        n_out_err;
    logic [15:0] n_xfer_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .xfer_cnt  (xfer_cnt)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (n_rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .in_mode   (n_in_mode),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .out_err   (n_out_err),
        .xfer_cnt  (n_xfer_cnt)
    );

    // Reference: result as an integer value plus error flag
    function automatic logic [64:0] ref_ext(input int iw, input int ow,
                                            input longint unsigned d,
                                            input logic [1:0] m);
        longint unsigned v;
        longint unsigned r;
        logic e;
        v = d % (64'd1 << iw);
        e = (m == 2'd3) || (m == 2'd2 && !UPPER);
        if (m == 2'd0 && v >= (64'd1 << (iw - 1)))
            r = v + ((64'd1 << ow) - (64'd1 << iw));
        else if (m == 2'd2 && UPPER)
            r = v * (64'd1 << (ow - iw));
        else
            r = v;
        r = r % (64'd1 << ow);
        return {e, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [15:0] d, input logic [1:0] m);
        in_data = d;
        in_mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 16'hFFFF;
        in_mode = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_xfer_cnt got=%h exp=0", xfer_cnt);
        end
        checks++;
        if (out_data !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got=%h/%b exp=0/0", out_data, out_err);
        end
    endtask

    task automatic test_modes;
        logic [31:0] fx_exp [4];
        logic        fx_err [4];
        logic [64:0] r;
        logic [15:0] d;
        logic [1:0]  m;
        fx_exp[0] = 32'hFFFF8001; fx_err[0] = 1'b0;
        fx_exp[1] = 32'h00008001; fx_err[1] = 1'b0;
`ifdef IMM_EXT_UPPER_EN
        fx_exp[2] = 32'h80010000; fx_err[2] = 1'b0;
`else
        fx_exp[2] = 32'h00008001; fx_err[2] = 1'b1;
`endif
        fx_exp[3] = 32'h00008001; fx_err[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                d = 16'h8001;
                m = 2'(i);
            end else begin
                d = 16'($urandom);
                m = 2'($urandom_range(0, 3));
                r = ref_ext(16, 32, 64'(d), m);
                fx_exp[i % 4] = r[31:0];
                fx_err[i % 4] = r[64];
            end
            push_one(d, m);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fx_exp[i % 4] ||
                out_err !== fx_err[i % 4]) begin
                errors++;
                $display("FAIL mode%0d_d%h got=%b/%h/%b exp=1/%h/%b",
                         m, d, out_valid, out_data, out_err,
                         fx_exp[i % 4], fx_err[i % 4]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mode_drain got=%b exp=0", out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        in_mode = 2'd1;
        in_valid = 1'b1;
        in_data = 16'h0001;
        tick();
        in_data = 16'h0002;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd1) begin
            errors++;
            $display("FAIL bp_full got=%b/%b/%h exp=0/1/1",
                     in_ready, out_valid, out_data);
        end
        in_data = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_data !== 32'd1 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got=%b/%h exp=0/1", i, in_ready,
                         out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_out2 got=%b/%h/%b exp=1/2/1", out_valid,
                     out_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_out3 got=%b/%h/%b exp=1/3/1", out_valid,
                     out_data, in_ready);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_done got=%b/%0d exp=0/3", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_streaming;
        logic [64:0] q[$];
        logic [64:0] e;
        int sent;
        int got;
        do_reset();
        sent = 0;
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (sent < 10);
            in_data = 16'($urandom);
            in_mode = 2'($urandom_range(0, 3));
            if (c >= 1 && c <= 10) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bubble c=%0d got=%b exp=1", c,
                             out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got=%h exp=none", out_data);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (out_data !== e[31:0] || out_err !== e[64]) begin
                        errors++;
                        $display("FAIL stream_data got=%h/%b exp=%h/%b",
                                 out_data, out_err, e[31:0], e[64]);
                    end
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready c=%0d got=%b exp=1", c,
                         in_ready);
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_ext(16, 32, 64'(in_data), in_mode));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != 10 || xfer_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stream_count got=%0d/%0d exp=10/10", got, xfer_cnt);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        push_one(16'h0005, 2'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rmid_pre got=%b/%0d exp=0/1", in_ready, xfer_cnt);
        end
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rmid_post got=%b/%b/%0d exp=0/1/0", out_valid,
                     in_ready, xfer_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL rmid_empty got=%b/%h exp=0/0", out_valid, out_data);
        end
    endtask

    task automatic test_narrow;
        logic [64:0] q[$];
        logic [64:0] e;
        int got;
        int cyc;
        n_rst_n = 1'b0;
        n_in_valid = 1'b0;
        n_out_ready = 1'b0;
        tick();
        n_rst_n = 1'b1;
        checks++;
        if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1 || n_xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL n_reset got=%b/%b/%0d exp=0/1/0", n_out_valid,
                     n_in_ready, n_xfer_cnt);
        end
        got = 0;
        cyc = 0;
        n_out_ready = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            while (got < 65535 + phase && cyc < 70000) begin
                n_in_valid = 1'b1;
                n_in_data = 8'($urandom);
                n_in_mode = 2'($urandom_range(0, 3));
                if (n_out_valid && n_out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL n_extra got=%h exp=none", n_out_data);
                    end else begin
                        e = q.pop_front();
                        got++;
                        if (n_out_data !== e[7:0] || n_out_err !== e[64]) begin
                            errors++;
                            $display("FAIL n_data got=%h/%b exp=%h/%b",
                                     n_out_data, n_out_err, e[7:0], e[64]);
                        end
                    end
                end
                if (n_in_valid && n_in_ready)
                    q.push_back(ref_ext(8, 8, 64'(n_in_data), n_in_mode));
                tick();
                cyc++;
            end
            checks++;
            if (got != 65535 + phase) begin
                errors++;
                $display("FAIL n_timeout got=%0d exp=%0d", got, 65535 + phase);
            end
            checks++;
            if (n_xfer_cnt !== 16'hFFFF) begin
                errors++;
                $display("FAIL n_sat%0d got=%h exp=ffff", phase, n_xfer_cnt);
            end
        end
        n_in_valid = 1'b0;
        n_out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_mode = '0;
        n_rst_n = 1'b0;
        n_in_valid = 1'b0;
        n_out_ready = 1'b0;
        n_in_data = '0;
        n_in_mode = '0;
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width; legal range 2..OUT_W.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal range IN_W..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers an immediate.
REQ-006 SHALL have port in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  IN_W  raw immediate.
REQ-008 SHALL have port in_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper (shift left by OUT_W-IN_W), 11 reserved.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 SHALL have port out_data  output  OUT_W  extended result.
REQ-012 SHALL have port out_err  output  1  result came from an illegal mode; qualified by out_valid.
REQ-013 SHALL have port xfer_cnt  output  16  saturating count of output transfers.

Function
REQ-014 SHALL compute sign mode as {OUT_W-IN_W copies of in_data[IN_W-1], in_data}; zero mode as zero-padded in_data.
REQ-015 SHALL compute upper mode as {in_data, OUT_W-IN_W zeros}; when OUT_W==IN_W all modes give in_data.
REQ-016 SHALL treat an illegal mode as zero-extend with err=1; err=0 otherwise.
REQ-017 SHALL compute the result on the accepting cycle and store {data, err} in a 2-entry FIFO; no value is ever recomputed.
REQ-018 SHALL give latency 1: accepted at edge N into an empty FIFO -> out_valid high after edge N, holding that result.
REQ-019 SHALL drive in_ready = (count < 2), registered-state only, with no combinational path from out_ready.
REQ-020 SHALL hold out_data/out_err stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous push and pop with count 1, keep count 1 and present the new entry next cycle.
REQ-022 SHALL, on simultaneous push and pop with count 0, never occur (out_valid low); with count 2, not occur (in_ready low).
REQ-023 SHALL deliver results in acceptance order; pointers wrap modulo 2.
REQ-024 SHALL increment xfer_cnt on each output transfer, saturating at 16'hFFFF.

Reset
REQ-025 SHALL, while rst_n low at a clock edge, set count 0, pointers 0, out_valid 0, in_ready 1 after the edge, xfer_cnt 0, out_data 0, out_err 0.
REQ-026 SHALL discard buffered entries on reset mid-operation; no transfer completes on a reset cycle.

Configuration
REQ-027 SHALL honour macro IMM_EXT_UPPER_EN: defined -> mode 10 is upper per REQ-015; undefined -> mode 10 is illegal per REQ-016 and no shift logic is built.

Structure
REQ-028 SHALL place mode constants (MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_RSVD) and FIFO depth constant 2 in shared package imm_ext_pkg.
REQ-029 SHALL isolate the pure extension logic in one combinational sub-module imm_ext_comb (in_data, in_mode -> data, err); FIFO, handshake and counter stay in imm_ext_pipe.

Verification
REQ-030 SHALL check defaults, mode 00, in_data 16'h8001 -> out_data 32'hFFFF8001, out_err 0, one cycle after acceptance.
REQ-031 SHALL check mode 01, 16'h8001 -> 32'h00008001; mode 10 with macro -> 32'h80010000, without macro -> 32'h00008001 and out_err 1; mode 11 -> 32'h00008001, out_err 1.
REQ-032 SHALL check backpressure: out_ready 0, push 16'h0001, 16'h0002 -> in_ready 0 after second; third offer held; release -> outputs 1, 2, 3 in order, data stable while stalled.
REQ-033 SHALL check streaming: in_valid and out_ready held 1 for 10 cycles -> 10 transfers in consecutive cycles after first latency, count never exceeds 1, xfer_cnt 10.
REQ-034 SHALL check reset mid-operation: FIFO holding 2 entries, rst_n low one edge -> out_valid 0, in_ready 1, xfer_cnt 0 afterward.
REQ-035 SHALL check IN_W=8, OUT_W=8 -> output equals input for modes 00/01/10, and xfer_cnt saturation by forcing 16'hFFFF then one transfer -> stays 16'hFFFF.
